fan_speed_monitor: RTL and testbench
====================================

FAN_SPEED_MONITOR -- requirements
Module: fan_speed_monitor

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 100000000, clk frequency in Hz.
REQ-002 SHALL have parameter SPINUP_SECONDS, default 10, grace period after enable before under-speed checks apply.
REQ-003 SHALL have parameter BAD_SAMPLES, default 3 (legal 1..15), consecutive low samples that cause a fault.
REQ-004 SHALL have parameter STALE_SECONDS, default 20, maximum gap between rpmValid strobes in RUN/WARN.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port fanEnable  input  1  fan commanded on.
REQ-008 SHALL have port rpmValid  input  1  one-cycle strobe: fanRPM holds a new measurement.
REQ-009 SHALL have port fanRPM  input  16  measured speed, unsigned RPM.
REQ-010 SHALL have port minRPM  input  16  under-speed limit, quasi-static.
REQ-011 SHALL have port hystRPM  input  16  recovery hysteresis, quasi-static.
REQ-012 SHALL have port faultClear  input  1  one-cycle strobe releasing a latched fault.
REQ-013 SHALL have port fanState  output  3  state: OFF=0, SPINUP=1, RUN=2, WARN=3, FAULT=4.
REQ-014 SHALL have port fanWarn  output  1  high exactly when fanState==WARN.
REQ-015 SHALL have port fanFault  output  1  high exactly when fanState==FAULT.
REQ-016 SHALL have port lastRPM  output  16  most recent fanRPM captured on rpmValid.

Function
REQ-017 SHALL generate a one-cycle secTick every CLOCK_RATE cycles from a free-running down-counter; the counter reloads to CLOCK_RATE-1 and ticks on reaching 0.
REQ-018 SHALL register all outputs; fanState/fanWarn/fanFault change on the clock edge that registers the triggering event (1-cycle latency).
REQ-019 SHALL load lastRPM with fanRPM on every rpmValid in every state.
REQ-020 OFF: fanEnable=1 -> SPINUP; spin-up timer loads SPINUP_SECONDS, badCount=0.
REQ-021 SPINUP: timer decrements on secTick; on secTick with timer==1 -> RUN; on rpmValid with fanRPM >= minRPM+hystRPM -> RUN early; low samples are ignored.
REQ-022 On entry to RUN, stale timer SHALL load STALE_SECONDS.
REQ-023 RUN: rpmValid with fanRPM < minRPM sets badCount=1 and goes to WARN, or directly to FAULT if BAD_SAMPLES==1.
REQ-024 WARN: rpmValid with fanRPM < minRPM increments badCount; reaching BAD_SAMPLES -> FAULT.
REQ-025 WARN: rpmValid with fanRPM >= minRPM+hystRPM -> RUN, badCount=0; values between limits keep WARN, badCount unchanged.
REQ-026 SHALL form minRPM+hystRPM as a 17-bit sum; no wrap, so a sum above 65535 is never met.
REQ-027 RUN/WARN: stale timer reloads to STALE_SECONDS on rpmValid, else decrements on secTick; secTick with timer==1 -> FAULT.
REQ-028 fanEnable=0 in SPINUP/RUN/WARN -> OFF next edge; timers and badCount cleared.
REQ-029 FAULT is latched regardless of fanEnable; faultClear -> OFF; faultClear outside FAULT is ignored.
REQ-030 Priorities in one cycle: faultClear/fanEnable=0 over rpmValid; rpmValid reload over stale expiry; rpmValid decisions over spin-up timer expiry.
REQ-031 Unused state encodings SHALL return to OFF on the next edge.

Reset
REQ-032 rst_n low SHALL immediately force fanState=OFF, fanWarn=0, fanFault=0, lastRPM=0, badCount=0, all timers 0, prescaler CLOCK_RATE-1.
REQ-033 After rst_n rises, the first secTick SHALL occur CLOCK_RATE cycles later; a reset mid-FAULT discards the latched fault.

Verification (CLOCK_RATE=100, SPINUP=10, BAD=3, STALE=20, minRPM=1000, hystRPM=100)
REQ-034 fanEnable=1, no strobes -> SPINUP for 10 ticks, then RUN; fanFault stays 0.
REQ-035 RUN; strobes 900,900,900 -> WARN after 1st (fanWarn=1), FAULT after 3rd (fanFault=1, lastRPM=900).
REQ-036 WARN with badCount=2; strobe 1050 -> stays WARN, badCount 2; strobe 1100 -> RUN, badCount 0.
REQ-037 RUN, strobes stop -> FAULT on 20th secTick after last strobe; strobe on that expiry cycle -> stays RUN.
REQ-038 FAULT, fanEnable=0 -> stays FAULT; faultClear -> OFF; faultClear with fanEnable=1 -> OFF then SPINUP.
REQ-039 rst_n pulsed low mid-WARN -> outputs zero asynchronously, fanState=OFF before next clk edge.

Source files
------------

// File: rtl/fan_speed_monitor.sv
// Fan supervisor: spin-up grace, under-speed/stale detection with hysteresis, latched fault.
// State and flags update on the edge after the triggering event; pure monitor, no backpressure.
module fan_speed_monitor #(
    parameter int unsigned CLOCK_RATE     = 100000000,
    parameter int unsigned SPINUP_SECONDS = 10,
    parameter int unsigned BAD_SAMPLES    = 3,
    parameter int unsigned STALE_SECONDS  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fanEnable,
    input  logic        rpmValid,
    input  logic [15:0] fanRPM,
    input  logic [15:0] minRPM,
    input  logic [15:0] hystRPM,
    input  logic        faultClear,
    output logic [2:0]  fanState,
    output logic        fanWarn,
    output logic        fanFault,
    output logic [15:0] lastRPM
);

    localparam int unsigned PW = (CLOCK_RATE > 1) ? $clog2(CLOCK_RATE) : 1;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(CLOCK_RATE - 1);
    localparam logic [15:0]   SPIN_LOAD  = 16'(SPINUP_SECONDS);
    localparam logic [15:0]   STALE_LOAD = 16'(STALE_SECONDS);
    localparam logic [3:0]    BAD_LIM    = 4'(BAD_SAMPLES);
    localparam bit            BAD_ONE    = (BAD_SAMPLES == 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SPINUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_WARN   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          sec_tick;
    logic [15:0]   spin_tmr;
    logic [15:0]   stale_tmr;
    logic [3:0]    bad_cnt;
    logic [3:0]    bad_inc;
    logic [16:0]   rec_thr;
    logic          rpm_low;
    logic          rpm_ok;

    assign fanState = state;
    assign sec_tick = (presc == '0);
    assign bad_inc  = bad_cnt + 4'd1;
    // Recovery threshold kept 17 bits wide so a large min+hyst is simply unreachable.
    assign rec_thr  = {1'b0, minRPM} + {1'b0, hystRPM};
    assign rpm_low  = (fanRPM < minRPM);
    assign rpm_ok   = ({1'b0, fanRPM} >= rec_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= PRESC_LOAD;
        end else if (sec_tick) begin
            presc <= PRESC_LOAD;
        end else begin
            presc <= presc - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastRPM <= '0;
        end else if (rpmValid) begin
            lastRPM <= fanRPM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_OFF;
            fanWarn   <= 1'b0;
            fanFault  <= 1'b0;
            spin_tmr  <= '0;
            stale_tmr <= '0;
            bad_cnt   <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (fanEnable) begin
                        state    <= ST_SPINUP;
                        spin_tmr <= SPIN_LOAD;
                        bad_cnt  <= '0;
                    end
                end
                ST_SPINUP: begin
                    if (!fanEnable) begin
                        state     <= ST_OFF;
                        spin_tmr  <= '0;
                        stale_tmr <= '0;
                        bad_cnt   <= '0;
                    end else if (rpmValid && rpm_ok) begin
                        state     <= ST_RUN;
                        spin_tmr  <= '0;
                        stale_tmr <= STALE_LOAD;
                    end else if (sec_tick) begin
                        if (spin_tmr == 16'd1) begin
                            state     <= ST_RUN;
                            spin_tmr  <= '0;
                            stale_tmr <= STALE_LOAD;
                        end else if (spin_tmr != '0) begin
                            spin_tmr <= spin_tmr - 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!fanEnable) begin
                        state     <= ST_OFF;
                        spin_tmr  <= '0;
                        stale_tmr <= '0;
                        bad_cnt   <= '0;
                    end else if (rpmValid) begin
                        stale_tmr <= STALE_LOAD;
                        if (rpm_low) begin
                            bad_cnt <= 4'd1;
                            if (BAD_ONE) begin
                                state    <= ST_FAULT;
                                fanFault <= 1'b1;
                            end else begin
                                state   <= ST_WARN;
                                fanWarn <= 1'b1;
                            end
                        end
                    end else if (sec_tick) begin
                        if (stale_tmr == 16'd1) begin
                            state     <= ST_FAULT;
                            fanFault  <= 1'b1;
                            stale_tmr <= '0;
                        end else if (stale_tmr != '0) begin
                            stale_tmr <= stale_tmr - 16'd1;
                        end
                    end
                end
                ST_WARN: begin
                    if (!fanEnable) begin
                        state     <= ST_OFF;
                        fanWarn   <= 1'b0;
                        spin_tmr  <= '0;
                        stale_tmr <= '0;
                        bad_cnt   <= '0;
                    end else if (rpmValid) begin
                        stale_tmr <= STALE_LOAD;
                        if (rpm_low) begin
                            bad_cnt <= bad_inc;
                            if (bad_inc >= BAD_LIM) begin
                                state    <= ST_FAULT;
                                fanWarn  <= 1'b0;
                                fanFault <= 1'b1;
                            end
                        end else if (rpm_ok) begin
                            state   <= ST_RUN;
                            fanWarn <= 1'b0;
                            bad_cnt <= '0;
                        end
                    end else if (sec_tick) begin
                        if (stale_tmr == 16'd1) begin
                            state     <= ST_FAULT;
                            fanWarn   <= 1'b0;
                            fanFault  <= 1'b1;
                            stale_tmr <= '0;
                        end else if (stale_tmr != '0) begin
                            stale_tmr <= stale_tmr - 16'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Latched until explicitly released; fanEnable has no effect here.
                    if (faultClear) begin
                        state     <= ST_OFF;
                        fanFault  <= 1'b0;
                        spin_tmr  <= '0;
                        stale_tmr <= '0;
                        bad_cnt   <= '0;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    fanWarn   <= 1'b0;
                    fanFault  <= 1'b0;
                    spin_tmr  <= '0;
                    stale_tmr <= '0;
                    bad_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fan_speed_monitor.sv
// Randomized bench for fan_speed_monitor against a seconds/samples-level reference model.
module tb_fan_speed_monitor;

    localparam int CR    = 100;
    localparam int SPIN  = 10;
    localparam int BAD   = 3;
    localparam int STALE = 20;

    logic        clk;
    logic        rst_n;
    logic        fanEnable;
    logic        rpmValid;
    logic [15:0] fanRPM;
    logic [15:0] minRPM;
    logic [15:0] hystRPM;
    logic        faultClear;
    logic [2:0]  fanState;
    logic        fanWarn;
    logic        fanFault;
    logic [15:0] lastRPM;

    fan_speed_monitor #(
        .CLOCK_RATE     (CR),
        .SPINUP_SECONDS (SPIN),
        .BAD_SAMPLES    (BAD),
        .STALE_SECONDS  (STALE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fanEnable  (fanEnable),
        .rpmValid   (rpmValid),
        .fanRPM     (fanRPM),
        .minRPM     (minRPM),
        .hystRPM    (hystRPM),
        .faultClear (faultClear),
        .fanState   (fanState),
        .fanWarn    (fanWarn),
        .fanFault   (fanFault),
        .lastRPM    (lastRPM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int fail_count  = 0;

    // Reference model: state plus elapsed whole seconds since spin-up / since last sample.
    int          m_state;
    int          m_bad;
    int          m_since_en;
    int          m_since_strobe;
    logic [15:0] m_last;
    int          n_edges;

    task automatic check_val(input string tag, input longint got, input longint exp);
        check_count++;
        if (got != exp) begin
            fail_count++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("state", fanState, m_state);
        check_val("warn", fanWarn, (m_state == 3) ? 1 : 0);
        check_val("fault", fanFault, (m_state == 4) ? 1 : 0);
        check_val("lastRPM", lastRPM, m_last);
    endtask

    task automatic model_reset();
        m_state        = 0;
        m_bad          = 0;
        m_since_en     = 0;
        m_since_strobe = 0;
        m_last         = 16'd0;
        n_edges        = 0;
    endtask

    task automatic model_step();
        bit          tick;
        bit          low;
        bit          hi;
        int          thr;
        n_edges++;
        tick = ((n_edges % CR) == 0);
        thr  = int'(minRPM) + int'(hystRPM);
        low  = (int'(fanRPM) < int'(minRPM));
        hi   = (int'(fanRPM) >= thr);
        if (rpmValid) m_last = fanRPM;
        case (m_state)
            0: if (fanEnable) begin
                m_state = 1; m_since_en = 0; m_bad = 0;
            end
            1: begin
                if (!fanEnable) begin
                    m_state = 0; m_bad = 0;
                end else if (rpmValid && hi) begin
                    m_state = 2; m_since_strobe = 0;
                end else if (tick) begin
                    m_since_en++;
                    if (m_since_en == SPIN) begin
                        m_state = 2; m_since_strobe = 0;
                    end
                end
            end
            2, 3: begin
                if (!fanEnable) begin
                    m_state = 0; m_bad = 0;
                end else if (rpmValid) begin
                    m_since_strobe = 0;
                    if (low) begin
                        m_bad++;
                        m_state = (m_bad >= BAD) ? 4 : 3;
                    end else if (hi && m_state == 3) begin
                        m_state = 2; m_bad = 0;
                    end
                end else if (tick) begin
                    m_since_strobe++;
                    if (m_since_strobe >= STALE) m_state = 4;
                end
            end
            4: if (faultClear) begin
                m_state = 0; m_bad = 0;
            end
            default: m_state = 0;
        endcase
    endtask

    // Per phase: strobe rate (per mille), enable toggle rate (per mille), length, minRPM, hystRPM.
    int ph_vld [7] = '{30, 0, 80, 5, 40, 40, 40};
    int ph_tog [7] = '{1, 0, 2, 1, 1, 1, 0};
    int ph_len [7] = '{4000, 9000, 4000, 4000, 4000, 4000, 3000};
    int ph_min [7] = '{1000, 1000, 1000, 1000, 1000, 65500, 1000};
    int ph_hyst[7] = '{100, 100, 100, 100, 100, 100, 0};

    initial begin
        rst_n      = 1'b0;
        fanEnable  = 1'b0;
        rpmValid   = 1'b0;
        fanRPM     = 16'd0;
        minRPM     = 16'd1000;
        hystRPM    = 16'd100;
        faultClear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        for (int ph = 0; ph < 7; ph++) begin
            minRPM  = 16'(ph_min[ph]);
            hystRPM = 16'(ph_hyst[ph]);
            for (int cyc = 0; cyc < ph_len[ph]; cyc++) begin
                if (ph == 4 && cyc == 1500) begin
                    // Asynchronous reset pulse between clock edges.
                    #2 rst_n = 1'b0;
                    #1;
                    model_reset();
                    check_all();
                    @(negedge clk);
                    check_all();
                    rst_n = 1'b1;
                end
                if ($urandom_range(0, 999) < ph_tog[ph]) fanEnable = ~fanEnable;
                if (ph == 1 && cyc == 0) fanEnable = 1'b1;
                faultClear = ($urandom_range(0, 99) == 0);
                rpmValid   = ($urandom_range(0, 999) < ph_vld[ph]);
                case ($urandom_range(0, 3))
                    0:       fanRPM = 16'($urandom_range(850, 999));
                    1:       fanRPM = 16'($urandom_range(1000, 1099));
                    2:       fanRPM = 16'($urandom_range(1100, 1300));
                    default: fanRPM = 16'($urandom_range(0, 65535));
                endcase
                // Sometimes land a strobe exactly on the stale-expiry tick.
                if ((m_state == 2 || m_state == 3) && m_since_strobe == STALE - 1 &&
                    ((n_edges + 1) % CR) == 0 && $urandom_range(0, 1) == 1) begin
                    rpmValid = 1'b1;
                    fanRPM   = 16'd1200;
                end
                @(posedge clk);
                model_step();
                @(negedge clk);
                check_all();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
